// File: rtl/regfile_wb_arbiter_if.sv
// Writeback handshake bundle for regfile_wb_arbiter: A/B requester ports and the
// registered register-file write port with its pending mask.
interface regfile_wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          a_valid_i;
  logic          a_ready_o;
  logic [4:0]    a_rd_i;
  logic [31:0]   a_data_i;
  logic          b_valid_i;
  logic          b_ready_o;
  logic [4:0]    b_rd_i;
  logic [31:0]   b_data_i;
  logic          Reg_Write_o;
  logic [4:0]    Write_Register_o;
  logic [31:0]   Write_Data_o;
  logic [31:0]   pending_mask_o;
  logic [CW-1:0] fifo_count_o;

  modport slave (
    input  a_valid_i, a_rd_i, a_data_i, b_valid_i, b_rd_i, b_data_i,
    output a_ready_o, b_ready_o, Reg_Write_o, Write_Register_o, Write_Data_o,
           pending_mask_o, fifo_count_o
  );

  modport master (
    output a_valid_i, a_rd_i, a_data_i, b_valid_i, b_rd_i, b_data_i,
    input  a_ready_o, b_ready_o, Reg_Write_o, Write_Register_o, Write_Data_o,
           pending_mask_o, fifo_count_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares one register-file write port between a single-cycle source (A) and a
// FIFO-buffered multi-cycle source (B), with a registered write stage.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter bit FIXED_A_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_rr_b;    // 1: FIFO head wins the next contended cycle
  logic          r_we;
  logic [4:0]    r_wreg;
  logic [31:0]   r_wdata;

  logic          w_full, w_empty, w_push, w_contend;
  logic          w_grant_a, w_grant_b;
  logic [31:0]   w_mask;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = bus.b_valid_i & ~w_full;
  assign w_contend = bus.a_valid_i & ~w_empty;

  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (w_contend) begin
      if (FIXED_A_PRIO || !r_rr_b) w_grant_a = 1'b1;
      else                         w_grant_b = 1'b1;
    end else begin
      w_grant_a = bus.a_valid_i;
      w_grant_b = ~w_empty;
    end
  end

  // Storage needs no reset; validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= bus.b_rd_i;
      r_data[r_wptr] <= bus.b_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rr_b  <= 1'b0;
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_push)    r_wptr <= r_wptr + 1'b1;
      if (w_grant_b) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_grant_b})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_contend && !FIXED_A_PRIO) r_rr_b <= w_grant_a;
      if (w_grant_a) begin
        r_we    <= (bus.a_rd_i != 5'd0);
        r_wreg  <= bus.a_rd_i;
        r_wdata <= bus.a_data_i;
      end else if (w_grant_b) begin
        r_we    <= (r_rd[r_rptr] != 5'd0);
        r_wreg  <= r_rd[r_rptr];
        r_wdata <= r_data[r_rptr];
      end else begin
        r_we    <= 1'b0;
      end
    end
  end

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < r_count) w_mask[r_rd[r_rptr + AW'(k)]] = 1'b1;
    end
    if (r_we) w_mask[r_wreg] = 1'b1;
    w_mask[0] = 1'b0;
  end

  assign bus.a_ready_o        = w_grant_a;
  assign bus.b_ready_o        = ~w_full;
  assign bus.Reg_Write_o      = r_we;
  assign bus.Write_Register_o = r_wreg;
  assign bus.Write_Data_o     = r_wdata;
  assign bus.pending_mask_o   = w_mask;
  assign bus.fifo_count_o     = r_count;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: fixed-priority instance for reset/fill/x0/full cases,
// round-robin instance for alternation.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DEPTH(4)) fx_if ();
  regfile_wb_arbiter_if #(.DEPTH(4)) rr_if ();

  regfile_wb_arbiter #(.DEPTH(4), .FIXED_A_PRIO(1'b1)) dut_fx (
    .clk(clk), .reset(reset), .bus(fx_if.slave));
  regfile_wb_arbiter #(.DEPTH(4), .FIXED_A_PRIO(1'b0)) dut_rr (
    .clk(clk), .reset(reset), .bus(rr_if.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    fx_if.a_valid_i = 0; fx_if.a_rd_i = 0; fx_if.a_data_i = 0;
    fx_if.b_valid_i = 0; fx_if.b_rd_i = 0; fx_if.b_data_i = 0;
    rr_if.a_valid_i = 0; rr_if.a_rd_i = 0; rr_if.a_data_i = 0;
    rr_if.b_valid_i = 0; rr_if.b_rd_i = 0; rr_if.b_data_i = 0;
  endtask

  task automatic test_reset;
    fx_if.a_valid_i = 1; fx_if.a_rd_i = 5'd9; fx_if.a_data_i = 32'h99;
    for (int i = 1; i <= 3; i++) begin
      fx_if.b_valid_i = 1; fx_if.b_rd_i = 5'(i); fx_if.b_data_i = 32'(i);
      tick;
    end
    fx_if.b_valid_i = 0;
    checks++;
    if (fx_if.fifo_count_o !== 3'd3) begin
      failures++; $display("FAIL rst_precount: got %0d expected 3", fx_if.fifo_count_o);
    end
    reset = 1;
    tick; tick;
    reset = 0;
    idle_inputs();
    checks++;
    if (fx_if.fifo_count_o !== 3'd0 || fx_if.Reg_Write_o !== 1'b0 || fx_if.b_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_ctrl: count=%0d we=%0b brdy=%0b expected 0/0/1",
               fx_if.fifo_count_o, fx_if.Reg_Write_o, fx_if.b_ready_o);
    end
    checks++;
    if (fx_if.Write_Register_o !== 5'd0 || fx_if.Write_Data_o !== 32'd0 || fx_if.pending_mask_o !== 32'd0) begin
      failures++;
      $display("FAIL rst_data: wr=%0d wd=%0h mask=%0h expected 0/0/0",
               fx_if.Write_Register_o, fx_if.Write_Data_o, fx_if.pending_mask_o);
    end
    tick;
    checks++;
    if (fx_if.Reg_Write_o !== 1'b0 || fx_if.fifo_count_o !== 3'd0) begin
      failures++; $display("FAIL rst_after: we=%0b count=%0d expected 0/0",
                           fx_if.Reg_Write_o, fx_if.fifo_count_o);
    end
  endtask

  task automatic test_a_only;
    fx_if.a_valid_i = 1; fx_if.a_rd_i = 5'd5; fx_if.a_data_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (fx_if.a_ready_o !== 1'b1) begin
      failures++; $display("FAIL a_ready: got %0b expected 1", fx_if.a_ready_o);
    end
    tick;
    fx_if.a_valid_i = 0;
    checks++;
    if (fx_if.Reg_Write_o !== 1'b1 || fx_if.Write_Register_o !== 5'd5 || fx_if.Write_Data_o !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL a_write: we=%0b wr=%0d wd=%0h expected 1/5/deadbeef",
                           fx_if.Reg_Write_o, fx_if.Write_Register_o, fx_if.Write_Data_o);
    end
    checks++;
    if (fx_if.pending_mask_o !== 32'h0000_0020) begin
      failures++; $display("FAIL a_mask: got %0h expected 20", fx_if.pending_mask_o);
    end
    tick;
    checks++;
    if (fx_if.Reg_Write_o !== 1'b0 || fx_if.Write_Register_o !== 5'd5 || fx_if.Write_Data_o !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL a_hold: we=%0b wr=%0d wd=%0h expected 0/5/deadbeef",
                           fx_if.Reg_Write_o, fx_if.Write_Register_o, fx_if.Write_Data_o);
    end
  endtask

  task automatic test_b_fill;
    fx_if.a_valid_i = 1; fx_if.a_rd_i = 5'd0; fx_if.a_data_i = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      fx_if.b_valid_i = 1; fx_if.b_rd_i = 5'(i); fx_if.b_data_i = 32'(100 + i);
      #1;
      checks++;
      if (fx_if.b_ready_o !== 1'b1) begin
        failures++; $display("FAIL fill_bready%0d: got %0b expected 1", i, fx_if.b_ready_o);
      end
      tick;
    end
    fx_if.b_valid_i = 0;
    fx_if.a_valid_i = 0;
    checks++;
    if (fx_if.b_ready_o !== 1'b0 || fx_if.fifo_count_o !== 3'd4 || fx_if.pending_mask_o !== 32'h0000_001E) begin
      failures++; $display("FAIL fill_full: brdy=%0b count=%0d mask=%0h expected 0/4/1e",
                           fx_if.b_ready_o, fx_if.fifo_count_o, fx_if.pending_mask_o);
    end
    for (int i = 1; i <= 4; i++) begin
      tick;
      checks++;
      if (fx_if.Reg_Write_o !== 1'b1 || fx_if.Write_Register_o !== 5'(i) || fx_if.Write_Data_o !== 32'(100 + i)) begin
        failures++; $display("FAIL fill_drain%0d: we=%0b wr=%0d wd=%0d expected 1/%0d/%0d",
                             i, fx_if.Reg_Write_o, fx_if.Write_Register_o, fx_if.Write_Data_o, i, 100 + i);
      end
    end
    tick;
    checks++;
    if (fx_if.Reg_Write_o !== 1'b0 || fx_if.fifo_count_o !== 3'd0 || fx_if.pending_mask_o !== 32'd0) begin
      failures++; $display("FAIL fill_empty: we=%0b count=%0d mask=%0h expected 0/0/0",
                           fx_if.Reg_Write_o, fx_if.fifo_count_o, fx_if.pending_mask_o);
    end
  endtask

  task automatic test_x0;
    fx_if.b_valid_i = 1; fx_if.b_rd_i = 5'd0; fx_if.b_data_i = 32'h1234;
    tick;
    fx_if.b_valid_i = 0;
    checks++;
    if (fx_if.fifo_count_o !== 3'd1 || fx_if.pending_mask_o !== 32'd0 || fx_if.Reg_Write_o !== 1'b0) begin
      failures++; $display("FAIL x0_queued: count=%0d mask=%0h we=%0b expected 1/0/0",
                           fx_if.fifo_count_o, fx_if.pending_mask_o, fx_if.Reg_Write_o);
    end
    tick;
    checks++;
    if (fx_if.fifo_count_o !== 3'd0 || fx_if.Reg_Write_o !== 1'b0 || fx_if.pending_mask_o !== 32'd0) begin
      failures++; $display("FAIL x0_consumed: count=%0d we=%0b mask=%0h expected 0/0/0",
                           fx_if.fifo_count_o, fx_if.Reg_Write_o, fx_if.pending_mask_o);
    end
  endtask

  task automatic test_full_pop;
    fx_if.a_valid_i = 1; fx_if.a_rd_i = 5'd0; fx_if.a_data_i = 32'h0;
    for (int i = 11; i <= 14; i++) begin
      fx_if.b_valid_i = 1; fx_if.b_rd_i = 5'(i); fx_if.b_data_i = 32'(i);
      tick;
    end
    fx_if.a_valid_i = 0;
    fx_if.b_rd_i = 5'd20; fx_if.b_data_i = 32'd20;
    #1;
    checks++;
    if (fx_if.b_ready_o !== 1'b0) begin
      failures++; $display("FAIL fp_full: brdy=%0b expected 0", fx_if.b_ready_o);
    end
    tick;
    fx_if.b_valid_i = 0;
    checks++;
    if (fx_if.fifo_count_o !== 3'd3 || fx_if.b_ready_o !== 1'b1 || fx_if.Write_Register_o !== 5'd11) begin
      failures++; $display("FAIL fp_pop: count=%0d brdy=%0b wr=%0d expected 3/1/11",
                           fx_if.fifo_count_o, fx_if.b_ready_o, fx_if.Write_Register_o);
    end
    for (int i = 12; i <= 14; i++) begin
      tick;
      checks++;
      if (fx_if.Reg_Write_o !== 1'b1 || fx_if.Write_Register_o !== 5'(i)) begin
        failures++; $display("FAIL fp_drain%0d: we=%0b wr=%0d expected 1/%0d",
                             i, fx_if.Reg_Write_o, fx_if.Write_Register_o, i);
      end
    end
    tick;
    checks++;
    if (fx_if.Reg_Write_o !== 1'b0 || fx_if.fifo_count_o !== 3'd0) begin
      failures++; $display("FAIL fp_nopush: we=%0b count=%0d expected 0/0",
                           fx_if.Reg_Write_o, fx_if.fifo_count_o);
    end
  endtask

  task automatic test_round_robin;
    logic        exp_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0]  exp_wr  [6] = '{5'd20, 5'd21, 5'd7, 5'd22, 5'd8, 5'd23};
    logic [31:0] exp_wd  [6] = '{32'hA000_0014, 32'hA000_0015, 32'hB000_0007,
                                 32'hA000_0016, 32'hB000_0008, 32'hA000_0017};
    logic [4:0]  ard = 5'd20;
    for (int k = 0; k < 6; k++) begin
      rr_if.a_valid_i = 1; rr_if.a_rd_i = ard; rr_if.a_data_i = 32'hA000_0000 | 32'(ard);
      rr_if.b_valid_i = (k < 2);
      rr_if.b_rd_i    = (k == 0) ? 5'd7 : 5'd8;
      rr_if.b_data_i  = 32'hB000_0000 | 32'(rr_if.b_rd_i);
      #1;
      checks++;
      if (rr_if.a_ready_o !== exp_rdy[k]) begin
        failures++; $display("FAIL rr_grant%0d: a_ready=%0b expected %0b", k, rr_if.a_ready_o, exp_rdy[k]);
      end
      tick;
      checks++;
      if (rr_if.Reg_Write_o !== 1'b1 || rr_if.Write_Register_o !== exp_wr[k] || rr_if.Write_Data_o !== exp_wd[k]) begin
        failures++; $display("FAIL rr_write%0d: we=%0b wr=%0d wd=%0h expected 1/%0d/%0h",
                             k, rr_if.Reg_Write_o, rr_if.Write_Register_o, rr_if.Write_Data_o, exp_wr[k], exp_wd[k]);
      end
      if (exp_rdy[k]) ard = ard + 5'd1;
    end
    rr_if.a_valid_i = 0; rr_if.b_valid_i = 0;
    tick;
    checks++;
    if (rr_if.Reg_Write_o !== 1'b0 || rr_if.fifo_count_o !== 3'd0) begin
      failures++; $display("FAIL rr_idle: we=%0b count=%0d expected 0/0",
                           rr_if.Reg_Write_o, rr_if.fifo_count_o);
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    tick; tick;
    reset = 0;
    test_reset();
    test_a_only();
    test_b_fill();
    test_x0();
    test_full_pop();
    test_round_robin();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
